// File: rtl/axi_burst_writer.sv
// axi_burst_writer: AXI4 single-ID INCR burst write master (command -> AW, upstream beats -> W, B -> done/err)
// Ports: clk/rst (async active-high); cmd_valid/cmd_ready/cmd_addr/cmd_len command in;
// din_valid/din_ready/din_data upstream beats; done one-cycle completion pulse; err sticky bad-bresp flag;
// aw*_s_inf, w*_s_inf, b*_s_inf AXI4 write channels.
// Optional feature: define BRESP_CHECK_EN to latch err on a non-OKAY bresp; otherwise err is tied 0.
module axi_burst_writer #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 32,
  parameter int LEN_W = 8,
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [DATA_W-1:0] din_data,
  output logic              done,
  output logic              err,
  output logic [3:0]        awid_s_inf,
  output logic [ADDR_W-1:0] awaddr_s_inf,
  output logic [LEN_W-1:0]  awlen_s_inf,
  output logic [2:0]        awsize_s_inf,
  output logic [1:0]        awburst_s_inf,
  output logic              awvalid_s_inf,
  input  logic              awready_s_inf,
  output logic [DATA_W-1:0] wdata_s_inf,
  output logic              wlast_s_inf,
  output logic              wvalid_s_inf,
  input  logic              wready_s_inf,
  input  logic [3:0]        bid_s_inf,
  input  logic [1:0]        bresp_s_inf,
  input  logic              bvalid_s_inf,
  output logic              bready_s_inf
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t state;
  logic [LEN_W-1:0] cnt, len_q;
  logic [ADDR_W-1:0] addr_q;
  logic in_data;
  assign in_data = state == DATA;
  assign cmd_ready = state == IDLE;
  assign awid_s_inf = AXI_ID;
  assign awaddr_s_inf = addr_q;
  assign awlen_s_inf = len_q;
  assign awsize_s_inf = 3'($clog2(DATA_W / 8));
  assign awburst_s_inf = 2'b01;
  assign awvalid_s_inf = state == ADDR;
  assign wvalid_s_inf = in_data && din_valid;
  assign wdata_s_inf = in_data ? din_data : '0;
  assign wlast_s_inf = in_data && cnt == len_q;
  assign din_ready = in_data && wready_s_inf;
  assign bready_s_inf = state == RESP;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      len_q <= '0;
      addr_q <= '0;
      done <= 1'b0;
`ifdef BRESP_CHECK_EN
      err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          addr_q <= cmd_addr;
          len_q <= cmd_len;
          cnt <= '0;
          state <= ADDR;
`ifdef BRESP_CHECK_EN
          err <= 1'b0;
`endif
        end
        ADDR: if (awready_s_inf) state <= DATA;
        DATA: if (din_valid && wready_s_inf) begin
          cnt <= cnt + LEN_W'(1);
          if (cnt == len_q) state <= RESP;
        end
        RESP: if (bvalid_s_inf) begin
          state <= IDLE;
          done <= 1'b1;
`ifdef BRESP_CHECK_EN
          if (bresp_s_inf != 2'b00) err <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
`ifdef BRESP_CHECK_EN
  logic unused_b;
  assign unused_b = ^bid_s_inf;
`else
  logic unused_b;
  assign unused_b = ^{bid_s_inf, bresp_s_inf};
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_axi_burst_writer.sv
// tb_axi_burst_writer: directed table-driven bench for axi_burst_writer with a behavioural AXI slave
module tb_axi_burst_writer;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready;
  logic [31:0] cmd_addr = 0;
  logic [7:0] cmd_len = 0;
  logic din_valid = 0, din_ready;
  logic [127:0] din_data = 0;
  logic done, err;
  logic [3:0] awid_s_inf;
  logic [31:0] awaddr_s_inf;
  logic [7:0] awlen_s_inf;
  logic [2:0] awsize_s_inf;
  logic [1:0] awburst_s_inf;
  logic awvalid_s_inf, awready_s_inf = 0;
  logic [127:0] wdata_s_inf;
  logic wlast_s_inf, wvalid_s_inf, wready_s_inf = 0;
  logic [3:0] bid_s_inf = 0;
  logic [1:0] bresp_s_inf = 0;
  logic bvalid_s_inf = 0, bready_s_inf;
  int tot = 0, bad = 0;
`ifdef BRESP_CHECK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif
  axi_burst_writer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .done(done), .err(err), .awid_s_inf(awid_s_inf), .awaddr_s_inf(awaddr_s_inf),
    .awlen_s_inf(awlen_s_inf), .awsize_s_inf(awsize_s_inf), .awburst_s_inf(awburst_s_inf),
    .awvalid_s_inf(awvalid_s_inf), .awready_s_inf(awready_s_inf), .wdata_s_inf(wdata_s_inf),
    .wlast_s_inf(wlast_s_inf), .wvalid_s_inf(wvalid_s_inf), .wready_s_inf(wready_s_inf),
    .bid_s_inf(bid_s_inf), .bresp_s_inf(bresp_s_inf), .bvalid_s_inf(bvalid_s_inf),
    .bready_s_inf(bready_s_inf)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] addr;
    logic [7:0] len;
    bit stall;
    logic [1:0] bresp;
    int lat;
    bit exp_err;
  } vec_t;
  task automatic check(input string n, input logic [127:0] a, input logic [127:0] e);
    tot++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [127:0] pat(input logic [31:0] addr, input int b);
    return {addr, 32'(b), ~32'(b), 32'h1234_0000 + 32'(b)};
  endfunction
  task automatic check_idle_outputs();
    check("rst_awvalid", awvalid_s_inf, 0);
    check("rst_wvalid", wvalid_s_inf, 0);
    check("rst_wlast", wlast_s_inf, 0);
    check("rst_bready", bready_s_inf, 0);
    check("rst_din_ready", din_ready, 0);
    check("rst_wdata", wdata_s_inf, 0);
    check("rst_awaddr", awaddr_s_inf, 0);
    check("rst_awlen", awlen_s_inf, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cmd_ready", cmd_ready, 1);
  endtask
  // Runs one burst starting at a point just after a falling edge; returns in the done cycle
  // (or after a mid-burst reset when rst_at >= 0).
  task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input bit stall,
                           input logic [1:0] bresp, input int lat, input bit exp_err,
                           input bit hold, input int rst_at);
    int c, beats, aws;
    bit dv_hold, bv_hold, pa_stall, pw_stall, w_early;
    logic [127:0] pw_data;
    logic [31:0] pa_addr;
    cmd_valid = 1;
    cmd_addr = addr;
    cmd_len = len;
    bresp_s_inf = bresp;
    din_valid = 0;
    #1 check("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    c = 0; beats = 0; aws = 0;
    dv_hold = 0; bv_hold = 0; pa_stall = 0; pw_stall = 0;
    pw_data = 0; pa_addr = 0;
    forever begin
      @(negedge clk);
      c++;
      if (!hold) cmd_valid = 0;
      awready_s_inf = stall ? $urandom_range(0, 2) != 0 : 1'b1;
      wready_s_inf = stall ? $urandom_range(0, 2) != 0 : 1'b1;
      din_valid = (!stall || dv_hold) ? 1'b1 : $urandom_range(0, 2) != 0;
      bvalid_s_inf = (!stall || bv_hold) ? 1'b1 : $urandom_range(0, 2) != 0;
      din_data = pat(addr, beats);
      #1;
      if (c == 1) begin
        check("err_clear_on_cmd", err, 0);
        check("done_pulse_width", done, 0);
      end
      if (pa_stall) begin
        check("aw_hold_valid", awvalid_s_inf, 1);
        check("aw_hold_addr", awaddr_s_inf, pa_addr);
      end
      if (pw_stall) begin
        check("w_hold_valid", wvalid_s_inf, 1);
        check("w_hold_data", wdata_s_inf, pw_data);
      end
      w_early = wvalid_s_inf && aws == 0;
      if (wvalid_s_inf) check("w_after_aw", w_early, 0);
      if (awvalid_s_inf && awready_s_inf) begin
        aws++;
        check("awaddr", awaddr_s_inf, addr);
        check("awlen", awlen_s_inf, len);
        check("awsize", awsize_s_inf, 4);
        check("awburst", awburst_s_inf, 1);
        check("awid", awid_s_inf, 0);
      end
      if (wvalid_s_inf) check("wlast", wlast_s_inf, beats == int'(len));
      if (wvalid_s_inf && wready_s_inf) begin
        check("wdata", wdata_s_inf, pat(addr, beats));
        beats++;
      end
      check("cmd_ready_busy", cmd_ready, done);
      pa_stall = awvalid_s_inf && !awready_s_inf;
      pa_addr = awaddr_s_inf;
      pw_stall = wvalid_s_inf && !wready_s_inf;
      pw_data = wdata_s_inf;
      dv_hold = din_valid && !din_ready;
      bv_hold = bvalid_s_inf && !bready_s_inf;
      if (rst_at >= 0 && beats == rst_at) begin
        rst = 1;
        #1 check_idle_outputs();
        @(negedge clk);
        rst = 0;
        din_valid = 0;
        #1 check("cmd_ready_after_rst", cmd_ready, 1);
        return;
      end
      if (done) begin
        if (lat > 0) check("done_latency", c, lat);
        check("beat_count", beats, int'(len) + 1);
        check("aw_count", aws, 1);
        check("err_at_done", err, exp_err);
        return;
      end
      if (c > 3000) begin
        check("done_timeout", c, lat);
        return;
      end
    end
  endtask
  vec_t v[7];
  initial begin
    v[0] = '{32'h0001_0000, 8'd191, 1'b0, 2'b00, 195, 1'b0};
    v[1] = '{32'h0000_0020, 8'd0, 1'b0, 2'b00, 4, 1'b0};
    v[2] = '{32'h0000_1000, 8'd15, 1'b1, 2'b00, 0, 1'b0};
    v[3] = '{32'h0000_0040, 8'd3, 1'b0, 2'b10, 7, ERR_ON};
    v[4] = '{32'h0000_0080, 8'd1, 1'b0, 2'b00, 5, 1'b0};
    v[5] = '{32'h0000_FFF0, 8'd15, 1'b1, 2'b11, 0, ERR_ON};
    v[6] = '{32'h0000_0000, 8'd255, 1'b0, 2'b00, 259, 1'b0};
    repeat (2) @(negedge clk);
    check_idle_outputs();
    check("rst_awsize", awsize_s_inf, 4);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 7; i++)
      run_burst(v[i].addr, v[i].len, v[i].stall, v[i].bresp, v[i].lat, v[i].exp_err, 1'b0, -1);
    run_burst(32'h500, 8'd2, 1'b0, 2'b00, 6, 1'b0, 1'b1, -1);
    run_burst(32'h500, 8'd2, 1'b0, 2'b00, 6, 1'b0, 1'b0, -1);
    run_burst(32'h200, 8'd31, 1'b0, 2'b00, 0, 1'b0, 1'b0, 5);
    run_burst(32'h600, 8'd3, 1'b0, 2'b00, 7, 1'b0, 1'b0, -1);
    run_burst(32'h700, 8'd0, 1'b0, 2'b01, 4, ERR_ON, 1'b0, -1);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("idle_done_low", done, 0);
      check("idle_err_sticky", err, ERR_ON);
      check("idle_awvalid", awvalid_s_inf, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", tot, bad);
    $finish;
  end
endmodule

// File: doc/axi_burst_writer.md
# axi_burst_writer

Parametrised AXI4 single-ID burst write master for the ISP DRAM path. It accepts a write command (address plus beat count), issues one INCR burst on the AW channel, and streams beats from an upstream data port onto the W channel. It then collects the B response and reports completion with a one-cycle pulse and an optional sticky error. It replaces hand-sequenced AW/W/B driving in the ISP top-level FSM.

## Interface
- DATA_W, 128, W-channel data width in bits; power of two, 8..1024.
- ADDR_W, 32, address width.
- LEN_W, 8, width of the burst-length field (AXI awlen).
- AXI_ID, 0, constant value driven on awid_s_inf (4 bits).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  write command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  ADDR_W  burst start byte address, DATA_W/8 aligned.
- cmd_len  in  LEN_W  beats minus one (0 means 1 beat).
- din_valid  in  1  upstream beat valid.
- din_ready  out  1  upstream beat accepted when din_valid && din_ready.
- din_data  in  DATA_W  beat payload.
- done  out  1  one-cycle pulse on B handshake.
- err  out  1  sticky error flag; see Configuration.
- awid_s_inf  out  4  equals AXI_ID.
- awaddr_s_inf  out  ADDR_W  latched cmd_addr.
- awlen_s_inf  out  LEN_W  latched cmd_len.
- awsize_s_inf  out  3  equals log2(DATA_W/8).
- awburst_s_inf  out  2  constant 2'b01 (INCR).
- awvalid_s_inf  out  1  address valid.
- awready_s_inf  in  1  address ready.
- wdata_s_inf  out  DATA_W  write data.
- wlast_s_inf  out  1  last beat of burst.
- wvalid_s_inf  out  1  write data valid.
- wready_s_inf  in  1  write data ready.
- bid_s_inf  in  4  ignored.
- bresp_s_inf  in  2  write response.
- bvalid_s_inf  in  1  response valid.
- bready_s_inf  out  1  response ready.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_addr and cmd_len, clear beat counter, go to ADDR.
- ADDR: awvalid_s_inf=1 with awaddr and awlen stable. On awready_s_inf, go to DATA. No W beat is issued before the AW handshake.
- DATA: combinational pass-through: wvalid_s_inf=din_valid, wdata_s_inf=din_data, din_ready=wready_s_inf. wlast_s_inf=1 when beat counter == latched len. Each W handshake increments the counter. A handshake with wlast high goes to RESP.
- RESP: bready_s_inf=1. On bvalid_s_inf, go to IDLE and pulse done for exactly one cycle; done is registered and high in the cycle after the handshake.
- Outside their states: awvalid, wvalid, wlast, bready, din_ready and wdata are 0.
- Beat counter is LEN_W bits wide. Its maximum value equals a cmd_len of all-ones, so the counter never wraps within a burst.
- cmd_valid outside IDLE is ignored (cmd_ready=0). Commands are not queued.
- din_valid outside DATA is ignored and the beat is not consumed.

## Timing
- Reset: state=IDLE, counter=0, latched addr/len=0, done=0, err=0. All AXI valid/ready outputs are 0; awaddr and awlen read 0.
- A reset asserted mid-burst aborts immediately to IDLE with all of the above. No wlast or bready is produced.
- Command accepted at edge T: awvalid is high from T+1.
- With awready, wready, din_valid and bvalid all held high, an N-beat burst (cmd_len=N-1) gives:
  - AW handshake at T+1.
  - W beats at T+2..T+N+1.
  - B handshake at T+N+2.
  - done high during T+N+3 and cmd_ready high from T+N+3.
- Earliest next command acceptance is therefore N+3 cycles after the previous one.
- Backpressure on awready, wready or bvalid stalls the FSM indefinitely with outputs held stable, per AXI rules.

## Configuration
- BRESP_CHECK_EN defined: err is set at the B handshake if bresp_s_inf != 2'b00. err is cleared only by reset or by acceptance of a new command; it is never cleared within the same cycle it is set.
- BRESP_CHECK_EN undefined: err is tied 0 and bresp_s_inf is unused.

## Test plan
- Reset, then cmd_addr=0x10000, cmd_len=191, all slave readies=1, din_valid=1 with an incrementing pattern. Required: awaddr=0x10000, awlen=191, awsize=4 (DATA_W=128), exactly 192 W beats, wlast only on beat 192, one done pulse.
- cmd_len=0: a single beat carries wlast=1; done arrives 3 cycles after cmd acceptance plus one; cmd_ready is low throughout.
- Random wready, din_valid, awready and bvalid stalls with cmd_len=15: 16 beats delivered in order, with no data or valid change while stalled.
- bvalid with bresp=2'b10, BRESP_CHECK_EN defined: err=1 after done and cleared on the next cmd acceptance. With the macro undefined: err stays 0.
- rst pulsed at beat 5 of a 32-beat burst: all AXI outputs go 0 immediately, cmd_ready=1 after release, and a new 4-beat command completes normally.
- cmd_valid held high during a burst: only the first command is accepted, and the second is accepted in the cycle done is high.
